// File: rtl/sc_charge_sequencer_if.sv
// Shared sequencer types and the host/monitor bus.
// Both the master (host side) and slave (sequencer) views are declared here.
package sc_types_pkg;
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    CHECK_GRID = 3'd1,
    CHARGING   = 3'd2,
    WAIT       = 3'd3,
    FAULT      = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    GRID_NORMAL   = 2'd0,
    GRID_UNSTABLE = 2'd1,
    GRID_CRITICAL = 2'd2
  } grid_state_t;
endpackage

interface sc_charge_sequencer_if;
  logic                     vehicle_present;
  logic                     charge_request;
  sc_types_pkg::grid_state_t grid_state;
  logic                     ml_predict_instability;
  logic                     fault_flag;
  logic [3:0]               fault_code;
  logic                     fault_clear;
  sc_types_pkg::state_t     current_state;
  logic                     charge_enable;
  logic [7:0]               power_level;
  logic [3:0]               latched_fault_code;
  logic [1:0]               retry_count;

  modport master (
    output vehicle_present, charge_request,
    output grid_state, ml_predict_instability,
    output fault_flag, fault_code, fault_clear,
    input  current_state, charge_enable,
    input  power_level, latched_fault_code,
    input  retry_count
  );

  modport slave (
    input  vehicle_present, charge_request,
    input  grid_state, ml_predict_instability,
    input  fault_flag, fault_code, fault_clear,
    output current_state, charge_enable,
    output power_level, latched_fault_code,
    output retry_count
  );
endinterface

// File: rtl/sc_charge_sequencer.sv
// Charging sequencer: qualify grid, ramp power,
// back off on predicted instability, latch faults.
module sc_charge_sequencer
  import sc_types_pkg::*;
#(
  parameter int CHECK_CYCLES = 16,
  parameter int WAIT_TIMEOUT = 1024,
  parameter int MAX_RETRIES  = 3,
  parameter int RAMP_STEP    = 8,
  parameter int PWR_MAX      = 255,
  parameter int PWR_UNSTABLE = 128
) (
  input logic clk,
  input logic reset_n,
  sc_charge_sequencer_if.slave bus
);

  localparam int SW = $clog2(CHECK_CYCLES + 1);
  localparam int TW = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [8:0] RS9 = 9'(RAMP_STEP);
  localparam logic [8:0] PMAX9 = 9'(PWR_MAX);
  localparam logic [8:0] PUNS9 = 9'(PWR_UNSTABLE);
  localparam logic [3:0] CODE_RETRY = 4'b1000;
  localparam logic [3:0] CODE_TMO = 4'b1001;

  state_t        state_q, state_nx;
  logic          en_q, en_nx;
  logic [7:0]    pwr_q, pwr_nx;
  logic [3:0]    code_q, code_nx;
  logic [1:0]    rt_q, rt_nx;
  logic [SW-1:0] stab_q, stab_nx;
  logic [TW-1:0] tmr_q, tmr_nx;

  logic       live;
  logic       qual;
  logic       rt_ok;
  logic       tmo;
  logic [8:0] sum9;
  logic [8:0] tgt9;
  logic [8:0] cur9;

  assign live = bus.vehicle_present
             && bus.charge_request;
  assign qual = (bus.grid_state == GRID_NORMAL)
             && !bus.ml_predict_instability;
  assign rt_ok = 32'(rt_q) < MAX_RETRIES;
  assign tmo = (tmr_q + 1'b1) == TW'(WAIT_TIMEOUT);
  assign cur9 = {1'b0, pwr_q};
  assign sum9 = cur9 + RS9;

  // State and all sequencer registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      en_q    <= 1'b0;
      pwr_q   <= '0;
      code_q  <= '0;
      rt_q    <= '0;
      stab_q  <= '0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_nx;
      en_q    <= en_nx;
      pwr_q   <= pwr_nx;
      code_q  <= code_nx;
      rt_q    <= rt_nx;
      stab_q  <= stab_nx;
      tmr_q   <= tmr_nx;
    end
  end

  // Next state: fault, then loss of session, then local exits
  always_comb begin
    state_nx = state_q;
    if (state_q != FAULT && bus.fault_flag) begin
      state_nx = FAULT;
    end else if (state_q != FAULT && !live) begin
      state_nx = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (live) state_nx = CHECK_GRID;
        end
        CHECK_GRID: begin
          if (stab_q == SW'(CHECK_CYCLES))
            state_nx = CHARGING;
        end
        CHARGING: begin
          if (bus.ml_predict_instability)
            state_nx = rt_ok ? WAIT : FAULT;
        end
        WAIT: begin
          if (qual) state_nx = CHECK_GRID;
          else if (tmo) state_nx = FAULT;
        end
        FAULT: begin
          if (bus.fault_clear && !bus.fault_flag)
            state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Ramp target; critical grid holds the level
  always_comb begin
    tgt9 = cur9;
    unique case (bus.grid_state)
      GRID_NORMAL:   tgt9 = PMAX9;
      GRID_UNSTABLE: tgt9 = PUNS9;
      default:       tgt9 = cur9;
    endcase
  end

  // Next outputs and counters from the transition
  always_comb begin
    en_nx   = 1'b0;
    pwr_nx  = '0;
    code_nx = code_q;
    rt_nx   = rt_q;
    stab_nx = '0;
    tmr_nx  = '0;
    if (state_nx == FAULT && state_q != FAULT) begin
      if (bus.fault_flag)
        code_nx = bus.fault_code;
      else if (state_q == WAIT)
        code_nx = CODE_TMO;
      else
        code_nx = CODE_RETRY;
    end
    if (state_nx == IDLE)
      rt_nx = '0;
    if (state_q == CHECK_GRID
        && state_nx == CHECK_GRID)
      stab_nx = qual ? stab_q + 1'b1 : '0;
    if (state_nx == CHARGING)
      en_nx = 1'b1;
    if (state_q == CHARGING
        && state_nx == CHARGING) begin
      unique case (1'b1)
        (cur9 < tgt9):
          pwr_nx = (sum9 > tgt9) ? tgt9[7:0]
                                 : sum9[7:0];
        (cur9 > tgt9):
          pwr_nx = tgt9[7:0];
        default:
          pwr_nx = pwr_q;
      endcase
    end
    if (state_q == CHARGING && state_nx == WAIT)
      rt_nx = rt_q + 1'b1;
    if (state_q == WAIT && state_nx == WAIT)
      tmr_nx = tmr_q + 1'b1;
  end

  assign bus.current_state      = state_q;
  assign bus.charge_enable      = en_q;
  assign bus.power_level        = pwr_q;
  assign bus.latched_fault_code = code_q;
  assign bus.retry_count        = rt_q;

endmodule

// File: tb/tb_sc_charge_sequencer.sv
// Bench for sc_charge_sequencer: vector table
// plus hand sequences, scored through a queue.
module tb_sc_charge_sequencer;
  import sc_types_pkg::*;

  logic clk;
  logic reset_n;
  sc_charge_sequencer_if bus();

  sc_charge_sequencer dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    state_t     st;
    logic       en;
    logic [7:0] pw;
    logic [3:0] code;
    logic [1:0] rt;
  } exp_t;

  typedef struct {
    logic        vp;
    logic        cr;
    grid_state_t g;
    logic        ml;
    logic        ff;
    logic [3:0]  fc;
    logic        clr;
    state_t      st;
    logic        en;
    logic [7:0]  pw;
    logic [3:0]  code;
    logic [1:0]  rt;
  } vec_t;

  exp_t q[$];
  vec_t tbl[12];
  int checks = 0;
  int errors = 0;
  logic [3:0] ecode;
  logic [1:0] eret;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic score(input string tag);
    exp_t e;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      e = q.pop_front();
      chk({tag, ".state"}, 32'(bus.current_state), 32'(e.st));
      chk({tag, ".en"}, 32'(bus.charge_enable), 32'(e.en));
      chk({tag, ".pwr"}, 32'(bus.power_level), 32'(e.pw));
      chk({tag, ".code"}, 32'(bus.latched_fault_code), 32'(e.code));
      chk({tag, ".retry"}, 32'(bus.retry_count), 32'(e.rt));
    end
  endtask

  task automatic step(input string tag,
                      input logic vp, input logic cr,
                      input grid_state_t g, input logic ml,
                      input logic ff, input logic [3:0] fc,
                      input logic clr, input state_t st,
                      input logic en, input logic [7:0] pw,
                      input logic [3:0] code,
                      input logic [1:0] rt);
    bus.vehicle_present        = vp;
    bus.charge_request         = cr;
    bus.grid_state             = g;
    bus.ml_predict_instability = ml;
    bus.fault_flag             = ff;
    bus.fault_code             = fc;
    bus.fault_clear            = clr;
    q.push_back('{st, en, pw, code, rt});
    @(posedge clk);
    #1;
    score(tag);
  endtask

  task automatic run(input string tag,
                     input logic vp, input logic cr,
                     input grid_state_t g, input logic ml,
                     input state_t st, input logic en,
                     input logic [7:0] pw);
    step(tag, vp, cr, g, ml, 1'b0, 4'd0, 1'b0,
         st, en, pw, ecode, eret);
  endtask

  task automatic qualify(input string tag);
    run({tag, ".enter"}, 1, 1, GRID_NORMAL, 0,
        CHECK_GRID, 0, 8'd0);
    for (int i = 0; i < 16; i++)
      run({tag, ".chk"}, 1, 1, GRID_NORMAL, 0,
          CHECK_GRID, 0, 8'd0);
    run({tag, ".chg"}, 1, 1, GRID_NORMAL, 0,
        CHARGING, 1, 8'd0);
  endtask

  task automatic ramp(input string tag,
                      input grid_state_t g,
                      input int start, input int n);
    int v;
    for (int k = 1; k <= n; k++) begin
      v = start + 8 * k;
      if (v > 255) v = 255;
      run(tag, 1, 1, g, 0, CHARGING, 1, 8'(v));
    end
  endtask

  task automatic hold_wait(input string tag,
                           input int n);
    for (int i = 0; i < n; i++)
      run(tag, 1, 1, GRID_NORMAL, 1, WAIT, 0, 8'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{0,1,GRID_NORMAL,0,0,4'd0,0,IDLE,0,0,4'd0,0};
    tbl[1]  = '{1,0,GRID_NORMAL,0,0,4'd0,0,IDLE,0,0,4'd0,0};
    tbl[2]  = '{1,1,GRID_NORMAL,0,0,4'd0,0,CHECK_GRID,0,0,4'd0,0};
    tbl[3]  = '{1,1,GRID_UNSTABLE,0,0,4'd0,0,CHECK_GRID,0,0,4'd0,0};
    tbl[4]  = '{1,1,GRID_NORMAL,0,1,4'd5,0,FAULT,0,0,4'd5,0};
    tbl[5]  = '{1,1,GRID_NORMAL,0,1,4'd7,1,FAULT,0,0,4'd5,0};
    tbl[6]  = '{1,1,GRID_NORMAL,0,0,4'd0,0,FAULT,0,0,4'd5,0};
    tbl[7]  = '{1,1,GRID_NORMAL,0,0,4'd0,1,IDLE,0,0,4'd5,0};
    tbl[8]  = '{1,1,GRID_NORMAL,0,0,4'd0,0,CHECK_GRID,0,0,4'd5,0};
    tbl[9]  = '{1,0,GRID_NORMAL,0,0,4'd0,0,IDLE,0,0,4'd5,0};
    tbl[10] = '{1,1,GRID_NORMAL,0,1,4'd3,0,FAULT,0,0,4'd3,0};
    tbl[11] = '{0,0,GRID_NORMAL,0,0,4'd0,1,IDLE,0,0,4'd3,0};

    reset_n = 1'b0;
    bus.vehicle_present        = 0;
    bus.charge_request         = 0;
    bus.grid_state             = GRID_NORMAL;
    bus.ml_predict_instability = 0;
    bus.fault_flag             = 0;
    bus.fault_code             = 0;
    bus.fault_clear            = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.state", 32'(bus.current_state), 32'(IDLE));
    chk("rst.en", 32'(bus.charge_enable), 0);
    chk("rst.pwr", 32'(bus.power_level), 0);
    chk("rst.code", 32'(bus.latched_fault_code), 0);
    chk("rst.retry", 32'(bus.retry_count), 0);
    #2 reset_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++)
      step($sformatf("tbl%0d", i), tbl[i].vp, tbl[i].cr,
           tbl[i].g, tbl[i].ml, tbl[i].ff, tbl[i].fc,
           tbl[i].clr, tbl[i].st, tbl[i].en, tbl[i].pw,
           tbl[i].code, tbl[i].rt);
    ecode = 4'd3;
    eret  = 2'd0;

    qualify("qual");
    ramp("ramp", GRID_NORMAL, 0, 34);
    run("degrade", 1, 1, GRID_UNSTABLE, 0, CHARGING, 1, 8'd128);
    ramp("reramp", GRID_NORMAL, 128, 16);

    for (int p = 1; p <= 3; p++) begin
      eret = 2'(p);
      run("retry.wait", 1, 1, GRID_NORMAL, 1, WAIT, 0, 8'd0);
      qualify("retry.q");
      ramp("retry.r", GRID_NORMAL, 0, 1);
    end
    ecode = 4'b1000;
    run("retry.fault", 1, 1, GRID_NORMAL, 1, FAULT, 0, 8'd0);
    eret = 2'd0;
    step("retry.clr", 1, 1, GRID_NORMAL, 0, 0, 4'd0, 1,
         IDLE, 0, 8'd0, ecode, eret);

    qualify("tmo.q");
    ramp("tmo.r", GRID_NORMAL, 0, 1);
    eret = 2'd1;
    run("tmo.enter", 1, 1, GRID_NORMAL, 1, WAIT, 0, 8'd0);
    hold_wait("tmo.hold", 1023);
    ecode = 4'b1001;
    run("tmo.fault", 1, 1, GRID_NORMAL, 1, FAULT, 0, 8'd0);
    eret = 2'd0;
    step("tmo.clr", 1, 1, GRID_NORMAL, 0, 0, 4'd0, 1,
         IDLE, 0, 8'd0, ecode, eret);

    qualify("race.q");
    ramp("race.r", GRID_NORMAL, 0, 1);
    eret = 2'd1;
    run("race.enter", 1, 1, GRID_NORMAL, 1, WAIT, 0, 8'd0);
    hold_wait("race.hold", 1023);
    run("race.resume", 1, 1, GRID_NORMAL, 0, CHECK_GRID, 0, 8'd0);
    eret = 2'd0;
    run("race.drop", 1, 0, GRID_NORMAL, 0, IDLE, 0, 8'd0);

    qualify("flt.q");
    ramp("flt.r", GRID_NORMAL, 0, 2);
    ecode = 4'b0101;
    step("flt.enter", 1, 1, GRID_NORMAL, 0, 1, 4'b0101, 0,
         FAULT, 0, 8'd0, ecode, eret);
    step("flt.ignore", 1, 1, GRID_NORMAL, 0, 1, 4'b0110, 1,
         FAULT, 0, 8'd0, ecode, eret);
    step("flt.clr", 1, 1, GRID_NORMAL, 0, 0, 4'd0, 1,
         IDLE, 0, 8'd0, ecode, eret);

    qualify("unplug.q");
    ramp("unplug.r", GRID_NORMAL, 0, 3);
    run("unplug", 0, 1, GRID_NORMAL, 0, IDLE, 0, 8'd0);

    qualify("ares.q");
    ramp("ares.r", GRID_NORMAL, 0, 2);
    eret = 2'd1;
    run("ares.wait", 1, 1, GRID_NORMAL, 1, WAIT, 0, 8'd0);
    #2 reset_n = 1'b0;
    #1;
    chk("ares.state", 32'(bus.current_state), 32'(IDLE));
    chk("ares.en", 32'(bus.charge_enable), 0);
    chk("ares.pwr", 32'(bus.power_level), 0);
    chk("ares.code", 32'(bus.latched_fault_code), 0);
    chk("ares.retry", 32'(bus.retry_count), 0);
    @(posedge clk);
    #1;
    chk("ares.hold", 32'(bus.current_state), 32'(IDLE));
    reset_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sc_charge_sequencer.md
# sc_charge_sequencer

Top-level charging sequencer for the smart-charging core. It owns the registered `current_state` (IDLE, CHECK_GRID, CHARGING, WAIT, FAULT from `sc_types_pkg`) that the safety monitor decodes. It reacts to the monitor's `fault_flag`/`fault_code`, the grid classifier and the ML instability predictor. It drives the charger enable and a ramped power setpoint, with qualification, back-off, retry and fault-latch behaviour.

## Interface
- `CHECK_CYCLES`, 16: consecutive qualifying cycles required in CHECK_GRID before charging (≥1).
- `WAIT_TIMEOUT`, 1024: maximum cycles spent in WAIT before a timeout fault (≥1).
- `MAX_RETRIES`, 3: WAIT entries allowed per session (≥1).
- `RAMP_STEP`, 8: power increment per cycle while ramping up.
- `PWR_MAX`, 255: power target when the grid is GRID_NORMAL.
- `PWR_UNSTABLE`, 128: power target when the grid is GRID_UNSTABLE (≤ `PWR_MAX`).
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `vehicle_present` in 1: plug detected.
- `charge_request` in 1: user or host requests charging (level).
- `grid_state` in `grid_state_t`: GRID_NORMAL, GRID_UNSTABLE or GRID_CRITICAL.
- `ml_predict_instability` in 1: predictor flag.
- `fault_flag` in 1: from the safety monitor; combinational on `current_state` and the inputs.
- `fault_code` in 4: from the safety monitor.
- `fault_clear` in 1: single-cycle acknowledge pulse from the host.
- `current_state` out `state_t`: registered sequencer state.
- `charge_enable` out 1: charger contactor enable.
- `power_level` out 8: power setpoint.
- `latched_fault_code` out 4: cause of the last FAULT entry.
- `retry_count` out 2: WAIT entries in the current session.

## Operation
- Reset (asynchronous) forces these values, which also hold until the first clock after release:
  - `current_state` = IDLE
  - `charge_enable` = 0
  - `power_level` = 0
  - `latched_fault_code` = 0
  - `retry_count` = 0
  - all internal counters = 0
- Exit priority, evaluated every cycle in every non-FAULT state:
  1. `fault_flag`
  2. `vehicle_present` = 0, or `charge_request` = 0
  3. the state-specific conditions below
- `fault_flag` = 1 → FAULT. `latched_fault_code` takes `fault_code`; `power_level` becomes 0 and `charge_enable` becomes 0 on the same edge.
- Loss of vehicle or request → IDLE.
- IDLE:
  - `charge_enable` = 0, `power_level` = 0, `retry_count` cleared.
  - `vehicle_present` && `charge_request` → CHECK_GRID, with the stable counter cleared.
- CHECK_GRID:
  - A qualifying cycle is one with `grid_state` == GRID_NORMAL && !`ml_predict_instability`.
  - The stable counter increments on a qualifying cycle and clears to 0 otherwise.
  - When the counter reaches `CHECK_CYCLES` → CHARGING, with `power_level` starting at 0.
- CHARGING:
  - `charge_enable` = 1.
  - target = `PWR_MAX` if GRID_NORMAL, `PWR_UNSTABLE` if GRID_UNSTABLE.
  - If `power_level` < target: `power_level` = min(`power_level` + `RAMP_STEP`, target). Compute the sum 9-bit wide so it cannot wrap.
  - If `power_level` > target: `power_level` = target in one cycle (immediate step down).
  - `ml_predict_instability` → WAIT if `retry_count` < `MAX_RETRIES`. In that case `retry_count` increments, the WAIT timer clears, `power_level` = 0 and `charge_enable` = 0.
  - If the retry budget is exhausted → FAULT with `latched_fault_code` = 4'b1000.
  - GRID_CRITICAL is handled only through `fault_flag`; the sequencer does not decode it itself.
- WAIT:
  - `charge_enable` = 0, `power_level` = 0.
  - The timer increments every cycle.
  - GRID_NORMAL && !`ml_predict_instability` → CHECK_GRID, with the stable counter cleared.
  - Timer reaching `WAIT_TIMEOUT` → FAULT with `latched_fault_code` = 4'b1001.
- FAULT:
  - `charge_enable` = 0, `power_level` = 0.
  - `latched_fault_code` holds its value; it is captured only on FAULT entry.
  - `fault_clear` && !`fault_flag` → IDLE, and `retry_count` is cleared.
  - `fault_clear` while `fault_flag` = 1 is ignored; the block stays in FAULT.
- Simultaneous events:
  - `fault_flag` together with any other exit → FAULT wins.
  - WAIT timeout together with the resume condition on the same cycle → resume wins.

## Timing
- All outputs are registered and change only on a `clk` rising edge, or immediately on asynchronous reset.
- Decision latency is one cycle: the inputs sampled at edge N determine the state and outputs after edge N.
- Earliest path from request to CHARGING:
  - The request is sampled at edge 0; CHECK_GRID is entered after edge 0.
  - CHARGING is entered after edge `CHECK_CYCLES` + 1.
  - The first nonzero `power_level` (`RAMP_STEP`) appears one edge later.
- Ramp time from 0 to `PWR_MAX` with the defaults is ceil(255/8) = 32 cycles; the final step saturates at 255.
- No combinational path from any input to any output. The loop `fault_flag` → `current_state` is broken by the state register.
- Reset asserted mid-session: the block returns to the reset values asynchronously, and every latched code and counter is lost.

## Test plan
- **Qualification:** reset, then `vehicle_present` = `charge_request` = 1 with GRID_NORMAL throughout.
  - CHARGING entered after 17 edges.
  - `power_level` reads 8, 16, … 248, then 255 on the next edge, then holds.
- **Instability retry:** while CHARGING, pulse `ml_predict_instability` 1 cycle, four separate times (GRID_NORMAL between pulses).
  - `retry_count` reads 1, 2, 3 after the first three pulses.
  - The fourth pulse gives FAULT with `latched_fault_code` = 1000.
- **Grid degrade:** at `power_level` 255, drive GRID_UNSTABLE.
  - Next edge `power_level` = 128.
  - Return to GRID_NORMAL → ramp 136 … 255.
- **Wait timeout:** enter WAIT and hold `ml_predict_instability` = 1.
  - After 1024 cycles: FAULT, code 1001, `charge_enable` = 0.
- **Fault handling:** in CHARGING, assert `fault_flag` with `fault_code` = 0101.
  - FAULT is entered and `latched_fault_code` = 0101.
  - `fault_clear` with `fault_flag` = 1 → the block stays in FAULT.
  - `fault_clear` with `fault_flag` = 0 → IDLE.
- **Reset and unplug:** drop `vehicle_present` mid-ramp → IDLE and `power_level` = 0 next edge. Separately, assert `reset_n` = 0 between edges → all outputs become 0 immediately and `current_state` = IDLE.
